// File: rtl/shift_cmd_seq_if.sv
// Command handshake bundle for shift_cmd_seq.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; the master holds the fields stable while cmd_valid
// is high, and cmd_ready never depends combinationally on cmd_valid.
interface shift_cmd_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ser;
    logic             cmd_rot;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_ser, cmd_rot,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_ser, cmd_rot,
        output cmd_ready
    );
endinterface

// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq: turns one command (hold / shift right / shift left / load)
// into the mode, data_in and serial-in controls of a universal shift register.
// FSM: IDLE -> RUN (N cycles, or 1 for load) -> DONE (1 cycle) -> IDLE.
// A shift/hold with count 0 goes straight from IDLE to DONE.
// Optional feature: define ROTATE_EN to let a latched rot bit feed the
// register's own end bit (q_fb) back in as the serial-in bit.
module shift_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_cmd_seq_if.slave   cmd,
    input  logic [WIDTH-1:0] q_fb,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] data_in,
    output logic             sr,
    output logic             sl,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_RIGHT = 2'b01;
    localparam logic [1:0] OP_LEFT  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ser;
    logic             w_ready;
    logic             w_accept;
    logic             w_fill;

    assign w_ready       = (r_state == S_IDLE);
    assign w_accept      = cmd.cmd_valid && w_ready;
    assign cmd.cmd_ready = w_ready;
    assign o_dbg_state   = r_state;

`ifdef ROTATE_EN
    logic r_rot;

    // Latch the rotate request with the rest of the command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rot <= 1'b0;
        end else if (w_accept) begin
            r_rot <= cmd.cmd_rot;
        end
    end

    // Fill bit: the register's outgoing end bit when rotating, else the latched serial bit
    always_comb begin
        w_fill = r_ser;
        if (r_rot) begin
            w_fill = (r_op == OP_RIGHT) ? q_fb[0] : q_fb[WIDTH-1];
        end
    end
`else
    // Rotate inputs stay on the port list but have no effect in this build
    logic w_unused_rot;
    assign w_unused_rot = ^{cmd.cmd_rot, q_fb};
    assign w_fill       = r_ser;
`endif

    // Sequencer FSM with registered mode/data_in/busy/done; r_cnt counts
    // down remaining RUN cycles and leaves RUN on 1, so it never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_HOLD;
            r_cnt   <= '0;
            r_ser   <= 1'b0;
            mode    <= OP_HOLD;
            data_in <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        r_op  <= cmd.cmd_op;
                        r_ser <= cmd.cmd_ser;
                        busy  <= 1'b1;
                        if (cmd.cmd_op == OP_LOAD) begin
                            r_state <= S_RUN;
                            r_cnt   <= CNT_W'(1);
                            mode    <= OP_LOAD;
                            data_in <= cmd.cmd_data;
                        end else if (cmd.cmd_count == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_cnt   <= cmd.cmd_count;
                            mode    <= cmd.cmd_op;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        mode    <= OP_HOLD;
                        data_in <= '0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    mode    <= OP_HOLD;
                    data_in <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Serial-in bits: only the active shift direction carries the fill bit, only in RUN
    always_comb begin
        sr = 1'b0;
        sl = 1'b0;
        if (r_state == S_RUN) begin
            if (r_op == OP_RIGHT) begin
                sr = w_fill;
            end else if (r_op == OP_LEFT) begin
                sl = w_fill;
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Bench for shift_cmd_seq: drives commands into a 4-bit universal shift
// register model and checks sequencer outputs and register contents.
module tb_shift_cmd_seq;

    logic       clk;
    logic       rst;
    logic [3:0] q_reg;
    logic [1:0] mode;
    logic [3:0] data_in;
    logic       sr;
    logic       sl;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    shift_cmd_seq_if #(.WIDTH(4), .CNT_W(4)) cmd_if ();

    shift_cmd_seq #(.WIDTH(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd_if.slave),
        .q_fb        (q_reg),
        .mode        (mode),
        .data_in     (data_in),
        .sr          (sr),
        .sl          (sl),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit register, starts at 0000
    initial q_reg = 4'b0000;
    always @(posedge clk) begin
        case (mode)
            2'b01: q_reg <= {sr, q_reg[3:1]};
            2'b10: q_reg <= {q_reg[2:0], sl};
            2'b11: q_reg <= data_in;
            default: q_reg <= q_reg;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [3:0] data,
                             input logic ser, input logic rot);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_count = cnt;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_ser   = ser;
        cmd_if.cmd_rot   = rot;
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [3:0] count;
        logic [3:0] data;
        logic       ser;
        int         len;
        logic       exp_sr;
        logic       exp_sl;
        logic [3:0] exp_data;
        logic [3:0] exp_q;
    } vec_t;

    // Full command: handshake, len RUN cycles, one DONE cycle, back to IDLE
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check({v.name, " ready_before"}, 32'(cmd_if.cmd_ready), 32'd1);
        drive_cmd(v.op, v.count, v.data, v.ser, 1'b0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            check($sformatf("%s mode c%0d", v.name, i), 32'(mode), 32'(v.op));
            check($sformatf("%s data_in c%0d", v.name, i), 32'(data_in), 32'(v.exp_data));
            check($sformatf("%s sr c%0d", v.name, i), 32'(sr), 32'(v.exp_sr));
            check($sformatf("%s sl c%0d", v.name, i), 32'(sl), 32'(v.exp_sl));
            check($sformatf("%s busy c%0d", v.name, i), 32'(busy), 32'd1);
            check($sformatf("%s done c%0d", v.name, i), 32'(done), 32'd0);
            check($sformatf("%s ready c%0d", v.name, i), 32'(cmd_if.cmd_ready), 32'd0);
            @(negedge clk);
        end
        check({v.name, " done_pulse"}, 32'(done), 32'd1);
        check({v.name, " done_mode"}, 32'(mode), 32'd0);
        check({v.name, " done_busy"}, 32'(busy), 32'd1);
        check({v.name, " done_sr_sl"}, 32'({sr, sl}), 32'd0);
        @(negedge clk);
        check({v.name, " idle_done"}, 32'(done), 32'd0);
        check({v.name, " idle_busy"}, 32'(busy), 32'd0);
        check({v.name, " idle_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
        check({v.name, " reg"}, 32'(q_reg), 32'(v.exp_q));
    endtask

    vec_t vecs[11];
    vec_t v_load8;

    initial begin
        vecs[0]  = '{"load_1010",   2'b11, 4'd0,  4'b1010, 1'b0, 1,  1'b0, 1'b0, 4'b1010, 4'b1010};
        vecs[1]  = '{"load_0000",   2'b11, 4'd0,  4'b0000, 1'b0, 1,  1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[2]  = '{"sr3_ser1",    2'b01, 4'd3,  4'b0000, 1'b1, 3,  1'b1, 1'b0, 4'b0000, 4'b1110};
        vecs[3]  = '{"sl2_ser1",    2'b10, 4'd2,  4'b0000, 1'b1, 2,  1'b0, 1'b1, 4'b0000, 4'b1011};
        vecs[4]  = '{"hold4",       2'b00, 4'd4,  4'b1111, 1'b1, 4,  1'b0, 1'b0, 4'b0000, 4'b1011};
        vecs[5]  = '{"sr1_ser0",    2'b01, 4'd1,  4'b0000, 1'b0, 1,  1'b0, 1'b0, 4'b0000, 4'b0101};
        vecs[6]  = '{"sl15_max",    2'b10, 4'd15, 4'b0000, 1'b0, 15, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[7]  = '{"sr0_zero",    2'b01, 4'd0,  4'b0000, 1'b1, 0,  1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[8]  = '{"sl0_zero",    2'b10, 4'd0,  4'b0000, 1'b1, 0,  1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[9]  = '{"load_cnt7",   2'b11, 4'd7,  4'b0110, 1'b1, 1,  1'b0, 1'b0, 4'b0110, 4'b0110};
        vecs[10] = '{"sr2_ser1",    2'b01, 4'd2,  4'b0000, 1'b1, 2,  1'b1, 1'b0, 4'b0000, 4'b1101};
        v_load8  = '{"load_1000",   2'b11, 4'd0,  4'b1000, 1'b0, 1,  1'b0, 1'b0, 4'b1000, 4'b1000};

        // Reset
        rst = 1'b1;
        drive_cmd(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
        cmd_if.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst mode", 32'(mode), 32'd0);
        check("rst data_in", 32'(data_in), 32'd0);
        check("rst sr_sl", 32'({sr, sl}), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("rst state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Table-driven commands
        for (int k = 0; k < 11; k++) begin
            run_vec(vecs[k]);
        end

        // Rotate: load 1000, then shift left twice with rot=1, ser=0
        run_vec(v_load8);
        @(negedge clk);
        drive_cmd(2'b10, 4'd2, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("rot c0 mode", 32'(mode), 32'b10);
`ifdef ROTATE_EN
        check("rot c0 sl", 32'(sl), 32'd1);
        @(negedge clk);
        check("rot c1 reg", 32'(q_reg), 32'b0001);
        @(negedge clk);
        check("rot done", 32'(done), 32'd1);
        check("rot final reg", 32'(q_reg), 32'b0010);
`else
        check("rot c0 sl", 32'(sl), 32'd0);
        @(negedge clk);
        check("rot c1 reg", 32'(q_reg), 32'b0000);
        @(negedge clk);
        check("rot done", 32'(done), 32'd1);
        check("rot final reg", 32'(q_reg), 32'b0000);
`endif
        @(negedge clk);
        check("rot idle ready", 32'(cmd_if.cmd_ready), 32'd1);

        // Abort: shift right count 5, valid kept high while busy, rst on 2nd RUN cycle
        @(negedge clk);
        drive_cmd(2'b01, 4'd5, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("abort c0 mode", 32'(mode), 32'b01);
        check("abort c0 ready", 32'(cmd_if.cmd_ready), 32'd0);
        drive_cmd(2'b11, 4'd0, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        check("abort c1 mode", 32'(mode), 32'b01);
        check("abort c1 data_in", 32'(data_in), 32'd0);
        check("abort c1 busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort mode", 32'(mode), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("abort sr", 32'(sr), 32'd0);
        @(negedge clk);
        check("abort later done", 32'(done), 32'd0);
        check("abort later mode", 32'(mode), 32'd0);
        check("abort later busy", 32'(busy), 32'd0);

        // Reset wins over a simultaneous handshake
        drive_cmd(2'b11, 4'd0, 4'b1111, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rstprio busy", 32'(busy), 32'd0);
        check("rstprio mode", 32'(mode), 32'd0);
        check("rstprio data_in", 32'(data_in), 32'd0);
        check("rstprio ready", 32'(cmd_if.cmd_ready), 32'd1);
        rst = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("rstprio after busy", 32'(busy), 32'd0);
        check("rstprio after mode", 32'(mode), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
